// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: data width,
// divide iteration count, FSM state encoding and the sign-fixup helper.
package hilo_pkg;

    localparam int DATA_W        = 32;
    localparam int HILO_DIV_BITS = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Two's-complement negate a magnitude when the result must be negative.
    function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] mag,
                                                   input logic              neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider core, unsigned only. Loaded by start, then one
// quotient bit per cycle for DIV_BITS cycles. quotient/remainder present the
// result of the step being taken this cycle, so the value seen while last=1
// is the final answer and can be captured on that edge.
module div_iter
    import hilo_pkg::*;
#(
    parameter int DIV_BITS = HILO_DIV_BITS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_BITS);

    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   dvs_q;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo_nx;
    logic [DATA_W-1:0]   rem_nx;

    // One restoring step: shift in the next dividend bit, try a subtract,
    // keep it only if it did not borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        rem_nx = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_nx = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
    end

    assign last      = busy_q & (cnt_q == CNT_W'(DIV_BITS - 1));
    assign quotient  = quo_nx;
    assign remainder = rem_nx;

    // Iteration state: load on start, step while busy, drop busy after the last step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: owns HI/LO, runs a multi-cycle multiply and an
// iterative divide, services mthi/mtlo, and stalls EX while an op is busy.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int MUL_STAGES = 1,
    parameter int DIV_BITS   = HILO_DIV_BITS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic              is_mult,
    input  logic              is_multu,
    input  logic              is_div,
    input  logic              is_divu,
    input  logic              hi_wen,
    input  logic              lo_wen,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MCNT_W = 2;

    logic [1:0]               state_q;
    logic [MCNT_W-1:0]        mul_cnt_q;
    logic                     fire;
    logic                     is_mul_op;
    logic                     is_div_op;
    logic                     mul_last;
    logic [DATA_W-1:0]        abs_a;
    logic [DATA_W-1:0]        abs_b;
    logic [DATA_W-1:0]        op_a_p0;
    logic [DATA_W-1:0]        op_b_p0;
    logic                     mul_sgn_p0;
    logic                     neg_q_p0;
    logic                     neg_r_p0;
    logic signed [2*DATA_W-1:0] mul_a_ext;
    logic signed [2*DATA_W-1:0] mul_b_ext;
    logic signed [2*DATA_W-1:0] product;
    logic                     div_start;
    logic                     div_abort;
    logic                     div_last;
    logic [DATA_W-1:0]        div_quo;
    logic [DATA_W-1:0]        div_rem;

    assign is_mul_op = is_mult | is_multu;
    assign is_div_op = is_div | is_divu;
    assign fire      = req_valid & ~flush & (state_q == ST_IDLE);
    assign stall     = req_valid & ~flush &
                       (((state_q == ST_IDLE) & (is_mul_op | is_div_op)) |
                        (state_q == ST_MUL) | (state_q == ST_DIV));
    assign mul_last  = (mul_cnt_q == MCNT_W'(MUL_STAGES - 1));

    // Divider works on magnitudes; signed ops strip the sign here and restore it at write-back.
    always_comb begin
        abs_a = (is_div & rs_data[DATA_W-1]) ? (~rs_data + 1'b1) : rs_data;
        abs_b = (is_div & rt_data[DATA_W-1]) ? (~rt_data + 1'b1) : rt_data;
    end

    // Sign- or zero-extend the latched operands to 64 bits; the low 64 bits of
    // the product are then correct for both signed and unsigned multiply.
    always_comb begin
        mul_a_ext = mul_sgn_p0 ? {{DATA_W{op_a_p0[DATA_W-1]}}, op_a_p0} : {{DATA_W{1'b0}}, op_a_p0};
        mul_b_ext = mul_sgn_p0 ? {{DATA_W{op_b_p0[DATA_W-1]}}, op_b_p0} : {{DATA_W{1'b0}}, op_b_p0};
        product   = mul_a_ext * mul_b_ext;
    end

    assign div_start = fire & is_div_op;
    assign div_abort = flush & (state_q == ST_DIV);

    div_iter #(
        .DIV_BITS (DIV_BITS)
    ) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // ---- stage p0: operand / sign capture at issue ----
    // Operand latches are pure data and carry no reset.
    always_ff @(posedge clk) begin
        if (fire & is_mul_op) begin
            op_a_p0    <= rs_data;
            op_b_p0    <= rt_data;
            mul_sgn_p0 <= is_mult;
        end
        if (fire & is_div_op) begin
            neg_q_p0 <= is_div & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
            neg_r_p0 <= is_div & rs_data[DATA_W-1];
        end
    end

    // Control FSM plus HI/LO write-back (mthi/mtlo, product, quotient/remainder).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire) begin
                        if (is_mul_op) begin
                            mul_cnt_q <= '0;
                            state_q   <= ST_MUL;
                        end else if (is_div_op) begin
                            state_q   <= ST_DIV;
                        end
                        if (hi_wen) begin
                            hi <= rs_data;
                        end
                        if (lo_wen) begin
                            lo <= rs_data;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (mul_last) begin
                        hi      <= product[2*DATA_W-1:DATA_W];
                        lo      <= product[DATA_W-1:0];
                        state_q <= ST_DONE;
                    end else begin
                        mul_cnt_q <= mul_cnt_q + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (div_last) begin
                        hi      <= sign_fix(div_rem, neg_r_p0);
                        lo      <= sign_fix(div_quo, neg_q_p0);
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus
// randomized mult/div/mthi/mtlo traffic against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, is_mult, is_multu, is_div, is_divu;
    logic        hi_wen, lo_wen, flush;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(
        .MUL_STAGES (MS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .is_mult   (is_mult),
        .is_multu  (is_multu),
        .is_div    (is_div),
        .is_divu   (is_divu),
        .hi_wen    (hi_wen),
        .lo_wen    (lo_wen),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0;
        is_mult   = 1'b0;
        is_multu  = 1'b0;
        is_div    = 1'b0;
        is_divu   = 1'b0;
        hi_wen    = 1'b0;
        lo_wen    = 1'b0;
        flush     = 1'b0;
    endtask

    // Reference: full-width product with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    // Reference: {remainder, quotient} from magnitudes plus sign rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ua, ub, q, r;
        ua = (sgn && a[31]) ? 32'(-a) : a;
        ub = (sgn && b[31]) ? 32'(-b) : b;
        if (ub == 0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (sgn && (a[31] != b[31])) q = 32'(-q);
        if (sgn && a[31])            r = 32'(-r);
        return {r, q};
    endfunction

    // kind: 0 mult, 1 multu, 2 div, 3 divu. Runs to the DONE cycle and checks there.
    task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        logic [63:0] r;
        @(posedge clk); #1;
        clear_inputs();
        req_valid = 1'b1;
        is_mult   = (kind == 0);
        is_multu  = (kind == 1);
        is_div    = (kind == 2);
        is_divu   = (kind == 3);
        rs_data   = a;
        rt_data   = b;
        #1;
        check("stall_issue", 64'(stall), 64'd1);
        cyc = 1;
        while (cyc < 100) begin
            @(posedge clk); #1;
            if (!stall) break;
            cyc++;
        end
        check("stall_len", 64'(cyc), (kind < 2) ? 64'(MS + 1) : 64'd33);
        r = (kind < 2) ? ref_mul(a, b, kind == 0) : ref_div(a, b, kind == 2);
        m_hi = r[63:32];
        m_lo = r[31:0];
        check("hi_result", 64'(hi), 64'(m_hi));
        check("lo_result", 64'(lo), 64'(m_lo));
    endtask

    // mthi (which_hi=1) or mtlo (which_hi=0): no stall, written at the edge.
    task automatic run_mt(input bit which_hi, input logic [31:0] v);
        @(posedge clk); #1;
        clear_inputs();
        req_valid = 1'b1;
        hi_wen    = which_hi;
        lo_wen    = !which_hi;
        rs_data   = v;
        #1;
        check("mt_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        clear_inputs();
        if (which_hi) m_hi = v; else m_lo = v;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clear_inputs();
        rs_data = '0;
        rt_data = '0;
        resetn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        resetn = 1'b1;

        // Directed corner cases.
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(0, 32'hFFFF_FFFD, 32'd5);
        run_mt(1'b0, 32'h0000_1234);
        run_op(2, 32'hFFFF_FFF9, 32'd2);
        run_op(3, 32'd7, 32'd0);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2, 32'hFFFF_FFF9, 32'd0);

        // Flush on the 10th stall cycle of a divide.
        @(posedge clk); #1;
        clear_inputs();
        req_valid = 1'b1;
        is_div    = 1'b1;
        rs_data   = 32'd1000;
        rt_data   = 32'd3;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("flush_pre_stall", 64'(stall), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        clear_inputs();
        check("flush_hi", 64'(hi), 64'(m_hi));
        check("flush_lo", 64'(lo), 64'(m_lo));
        repeat (30) @(posedge clk);
        #1;
        check("flush_hi_late", 64'(hi), 64'(m_hi));
        check("flush_lo_late", 64'(lo), 64'(m_lo));
        run_mt(1'b1, 32'hCAFE_0001);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 5);
            if (k < 4) run_op(k, rand_operand(), rand_operand());
            else       run_mt(k == 4, $urandom);
        end

        // Asynchronous reset on the 5th cycle of a divide.
        run_mt(1'b1, 32'h1111_2222);
        @(posedge clk); #1;
        clear_inputs();
        req_valid = 1'b1;
        is_div    = 1'b1;
        rs_data   = 32'd99;
        rt_data   = 32'd4;
        repeat (4) begin
            @(posedge clk); #1;
        end
        resetn    = 1'b0;
        req_valid = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        clear_inputs();
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_hi_hold", 64'(hi), 64'd0);
        check("arst_lo_hold", 64'(lo), 64'd0);
        run_op(0, 32'h0001_0003, 32'hFFFF_FF00);

        @(posedge clk); #1;
        clear_inputs();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
